mem_port_arb: RTL and testbench
===============================

# mem_port_arb

Single-port memory arbiter that shares one external memory/bus port between the instruction-fetch stage and the memory-access (load/store) stage. It serialises the two requesters, holds the bus request stable until the slave acknowledges, and generates stall requests into the pipeline stall controller so that fetch and the MEM stage freeze until their access completes. It also handles fetch flushes and a bus-timeout abort.

## Interface
Parameters:
- TIMEOUT, default 16: maximum bus wait cycles (counted from bus_req assertion) before abort; legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on posedge clk
- rst  in  1  synchronous reset, active-high (`RstEnable` = 1'b1)
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched word, valid with if_ack
- if_ack  out  1  one-cycle fetch completion pulse
- dm_req  in  1  load/store request, held until dm_ack
- dm_we  in  1  1 = store
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_sel  in  4  byte lanes
- dm_rdata  out  32  load data, valid with dm_ack
- dm_ack  out  1  one-cycle data completion pulse
- flush  in  1  pipeline flush; kills in-flight/pending fetch
- bus_req  out  1  bus transaction request, registered
- bus_we, bus_addr[31:0], bus_wdata[31:0], bus_sel[3:0]  out  registered bus command
- bus_rdata  in  32  slave read data, valid with bus_ack
- bus_ack  in  1  slave completion, one cycle
- bus_err  out  1  one-cycle pulse with the ack of a timed-out access
- stallreq_if  out  1  if_req && !if_ack (combinational)
- stallreq_mem  out  1  dm_req && !dm_ack (combinational)

## Operation
- FSM states: IDLE, IF_BUSY, DM_BUSY, DONE.
- IDLE: if dm_req -> DM_BUSY, latch dm_* onto bus_*, bus_sel = dm_sel, bus_req=1. Else if if_req && !flush -> IF_BUSY, bus_we=0, bus_sel=4'b1111, bus_addr=if_addr. Else stay. Data always wins simultaneous requests (older instruction).
- IF_BUSY / DM_BUSY: bus_* held constant. On bus_ack: capture bus_rdata, bus_req<=0, -> DONE. Wait counter increments each busy cycle; when it reaches TIMEOUT without bus_ack: bus_req<=0, rdata<=0, set error, -> DONE.
- DONE (exactly one cycle): assert the owner's ack (if_ack or dm_ack), drive owner rdata, bus_err if timed out; no new grant this cycle; -> IDLE. Prevents reissue while the requester still holds req in the ack cycle.
- Flush: in IF_BUSY, set discard flag; transaction continues to bus_ack/timeout (bus not abandoned mid-cycle) but DONE suppresses if_ack and bus_err. Flush never affects DM_BUSY or a data DONE. Flush in DONE of a fetch suppresses that if_ack. Flush in IDLE blocks fetch grant that cycle.
- bus_ack in IDLE or DONE is ignored.
- Stores: dm_rdata = 0 in DONE.
- Outputs not acked hold previous rdata; only valid qualified by ack.

## Timing
- Reset: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_sel=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, bus_err=0, counter=0, discard=0. Reset mid-transaction drops bus_req next edge; no ack issued.
- Request sampled in IDLE at cycle N -> bus_req high N+1. bus_ack at cycle N+k (k≥1) -> state DONE, ack high at N+k+1. Minimum latency request->ack = 2 cycles with zero-wait slave.
- Back-to-back: next grant earliest in IDLE cycle after DONE; throughput one access per k+2 cycles.
- Timeout: bus_ack absent for TIMEOUT cycles of bus_req -> ack+bus_err in following cycle.
- Requester deasserts/changes req in the cycle after its ack.

## Test plan
- Fetch only, slave k=1, if_addr=0x0000_0040, bus_rdata=0x2408_0005 -> bus_req 1 cycle, if_ack at cycle 3 with if_rdata=0x2408_0005; stallreq_if high cycles 1-2.
- if_req and dm_req (load, addr 0x100) same cycle -> data served first, dm_ack, then fetch granted in IDLE after DONE; if_ack 3 cycles later (k=1).
- Store dm_sel=4'b0010, dm_wdata=0x0000_AB00 -> bus_we=1, bus_sel=0010, bus_wdata passthrough; dm_ack with dm_rdata=0.
- Fetch in flight, flush pulsed, bus_ack 2 cycles later -> no if_ack, FSM returns IDLE; pending dm_req then granted normally.
- Slave never acks, TIMEOUT=16 -> bus_req drops after 16 cycles, dm_ack and bus_err pulse together, dm_rdata=0.
- rst asserted while DM_BUSY -> next cycle all outputs at reset values, late bus_ack ignored.

Source files
------------

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one bus port between instruction fetch and load/store, data first, with flush discard and timeout abort
module mem_port_arb #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_sel,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic        stallreq_if,
  output logic        stallreq_mem
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, DONE} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_own_dm, r_discard, r_err;
  logic [31:0] r_if_rdata, r_dm_rdata;
  logic        w_done, w_kill, w_to;
  logic [31:0] w_data;
  assign w_done = r_state == DONE;
  assign w_kill = r_discard || flush;
  assign w_to   = r_cnt == 8'(TIMEOUT - 1);
  assign w_data = bus_ack ? bus_rdata : 32'h0;
  assign if_ack       = w_done && !r_own_dm && !w_kill;
  assign dm_ack       = w_done && r_own_dm;
  assign bus_err      = w_done && r_err && (r_own_dm || !w_kill);
  assign if_rdata     = r_if_rdata;
  assign dm_rdata     = r_dm_rdata;
  assign stallreq_if  = if_req && !if_ack;
  assign stallreq_mem = dm_req && !dm_ack;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_own_dm   <= 1'b0;
      r_discard  <= 1'b0;
      r_err      <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_sel    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_err     <= 1'b0;
          r_discard <= 1'b0;
          if (dm_req) begin
            r_state   <= DM_BUSY;
            r_own_dm  <= 1'b1;
            bus_req   <= 1'b1;
            bus_we    <= dm_we;
            bus_addr  <= dm_addr;
            bus_wdata <= dm_wdata;
            bus_sel   <= dm_sel;
          end else if (if_req && !flush) begin
            r_state  <= IF_BUSY;
            r_own_dm <= 1'b0;
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= if_addr;
            bus_sel  <= 4'b1111;
          end
        end
        IF_BUSY, DM_BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          if (flush && r_state == IF_BUSY) r_discard <= 1'b1;
          if (bus_ack || w_to) begin
            r_state <= DONE;
            bus_req <= 1'b0;
            r_err   <= !bus_ack;
            if (r_own_dm) r_dm_rdata <= bus_we ? 32'h0 : w_data;
            else if (!w_kill) r_if_rdata <= w_data;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: cycle-by-cycle vector table plus timeout and reset sequences for mem_port_arb
module tb_mem_port_arb;
  logic        clk = 0, rst = 1;
  logic        if_req = 0, dm_req = 0, dm_we = 0, flush = 0, bus_ack = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, bus_rdata = 0;
  logic [3:0]  dm_sel = 0;
  logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
  logic        if_ack, dm_ack, bus_req, bus_we, bus_err, stallreq_if, stallreq_mem;
  logic [3:0]  bus_sel;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_port_arb #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_sel(dm_sel),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .flush(flush), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );
  typedef struct {
    logic if_req; logic [31:0] if_addr;
    logic dm_req; logic dm_we; logic [31:0] dm_addr; logic [31:0] dm_wdata; logic [3:0] dm_sel;
    logic flush; logic b_ack; logic [31:0] b_rdata;
    logic e_breq; logic e_ifack; logic e_dmack; logic e_err; logic e_sif; logic e_smem;
    logic [31:0] e_ifrd; logic [31:0] e_dmrd;
    logic chk_bus; logic e_we; logic [31:0] e_addr; logic [31:0] e_wdata; logic [3:0] e_sel;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic run_vec(input vec_t v);
    if_req = v.if_req; if_addr = v.if_addr; dm_req = v.dm_req; dm_we = v.dm_we;
    dm_addr = v.dm_addr; dm_wdata = v.dm_wdata; dm_sel = v.dm_sel; flush = v.flush;
    bus_ack = v.b_ack; bus_rdata = v.b_rdata;
    #4;
    chk("bus_req", 32'(bus_req), 32'(v.e_breq));
    chk("if_ack", 32'(if_ack), 32'(v.e_ifack));
    chk("dm_ack", 32'(dm_ack), 32'(v.e_dmack));
    chk("bus_err", 32'(bus_err), 32'(v.e_err));
    chk("stallreq_if", 32'(stallreq_if), 32'(v.e_sif));
    chk("stallreq_mem", 32'(stallreq_mem), 32'(v.e_smem));
    chk("if_rdata", if_rdata, v.e_ifrd);
    chk("dm_rdata", dm_rdata, v.e_dmrd);
    if (v.chk_bus) begin
      chk("bus_we", 32'(bus_we), 32'(v.e_we));
      chk("bus_addr", bus_addr, v.e_addr);
      chk("bus_wdata", bus_wdata, v.e_wdata);
      chk("bus_sel", 32'(bus_sel), 32'(v.e_sel));
    end
    @(posedge clk); #1;
  endtask
  initial begin
    // if_req addr | dm_req we addr wdata sel | flush ack rdata || breq ifack dmack err sif smem ifrd dmrd || chk we addr wdata sel
    tv.push_back('{0,0,           0,0,0,0,0,          0,0,0,            0,0,0,0,0,0, 0,0,                      0,0,0,0,0});
    tv.push_back('{1,32'h40,      0,0,0,0,0,          0,0,0,            0,0,0,0,1,0, 0,0,                      0,0,0,0,0});
    tv.push_back('{1,32'h40,      0,0,0,0,0,          0,1,32'h24080005, 1,0,0,0,1,0, 0,0,                      1,0,32'h40,0,4'hf});
    tv.push_back('{1,32'h40,      0,0,0,0,0,          0,0,0,            0,1,0,0,0,0, 32'h24080005,0,           0,0,0,0,0});
    tv.push_back('{0,0,           0,0,0,0,0,          0,0,0,            0,0,0,0,0,0, 32'h24080005,0,           0,0,0,0,0});
    tv.push_back('{1,32'h80,      1,0,32'h100,0,4'hf, 0,0,0,            0,0,0,0,1,1, 32'h24080005,0,           0,0,0,0,0});
    tv.push_back('{1,32'h80,      1,0,32'h100,0,4'hf, 0,1,32'h11112222, 1,0,0,0,1,1, 32'h24080005,0,           1,0,32'h100,0,4'hf});
    tv.push_back('{1,32'h80,      1,0,32'h100,0,4'hf, 0,0,0,            0,0,1,0,1,0, 32'h24080005,32'h11112222, 0,0,0,0,0});
    tv.push_back('{1,32'h80,      0,0,0,0,0,          0,0,0,            0,0,0,0,1,0, 32'h24080005,32'h11112222, 0,0,0,0,0});
    tv.push_back('{1,32'h80,      0,0,0,0,0,          0,1,32'h33334444, 1,0,0,0,1,0, 32'h24080005,32'h11112222, 1,0,32'h80,0,4'hf});
    tv.push_back('{1,32'h80,      0,0,0,0,0,          0,0,0,            0,1,0,0,0,0, 32'h33334444,32'h11112222, 0,0,0,0,0});
    tv.push_back('{0,0,           0,0,0,0,0,          0,0,0,            0,0,0,0,0,0, 32'h33334444,32'h11112222, 0,0,0,0,0});
    tv.push_back('{0,0,           1,1,32'h200,32'hAB00,4'h2, 0,0,0,     0,0,0,0,0,1, 32'h33334444,32'h11112222, 0,0,0,0,0});
    tv.push_back('{0,0,           1,1,32'h200,32'hAB00,4'h2, 0,1,32'hDEADBEEF, 1,0,0,0,0,1, 32'h33334444,32'h11112222, 1,1,32'h200,32'hAB00,4'h2});
    tv.push_back('{0,0,           1,1,32'h200,32'hAB00,4'h2, 0,0,0,     0,0,1,0,0,0, 32'h33334444,0,           0,0,0,0,0});
    tv.push_back('{0,0,           0,0,0,0,0,          0,0,0,            0,0,0,0,0,0, 32'h33334444,0,           0,0,0,0,0});
    tv.push_back('{1,32'hC0,      0,0,0,0,0,          0,0,0,            0,0,0,0,1,0, 32'h33334444,0,           0,0,0,0,0});
    tv.push_back('{1,32'hC0,      0,0,0,0,0,          1,0,0,            1,0,0,0,1,0, 32'h33334444,0,           1,0,32'hC0,32'hAB00,4'hf});
    tv.push_back('{0,0,           1,0,32'h300,0,4'hf, 0,0,0,            1,0,0,0,0,1, 32'h33334444,0,           0,0,0,0,0});
    tv.push_back('{0,0,           1,0,32'h300,0,4'hf, 0,1,32'h55555555, 1,0,0,0,0,1, 32'h33334444,0,           0,0,0,0,0});
    tv.push_back('{0,0,           1,0,32'h300,0,4'hf, 0,0,0,            0,0,0,0,0,1, 32'h33334444,0,           0,0,0,0,0});
    tv.push_back('{0,0,           1,0,32'h300,0,4'hf, 0,0,0,            0,0,0,0,0,1, 32'h33334444,0,           0,0,0,0,0});
    tv.push_back('{0,0,           1,0,32'h300,0,4'hf, 0,1,32'h66666666, 1,0,0,0,0,1, 32'h33334444,0,           1,0,32'h300,0,4'hf});
    tv.push_back('{0,0,           1,0,32'h300,0,4'hf, 0,0,0,            0,0,1,0,0,0, 32'h33334444,32'h66666666, 0,0,0,0,0});
    tv.push_back('{0,0,           0,0,0,0,0,          0,0,0,            0,0,0,0,0,0, 32'h33334444,32'h66666666, 0,0,0,0,0});
    tv.push_back('{1,32'hE0,      0,0,0,0,0,          1,0,0,            0,0,0,0,1,0, 32'h33334444,32'h66666666, 0,0,0,0,0});
    tv.push_back('{1,32'hE0,      0,0,0,0,0,          0,0,0,            0,0,0,0,1,0, 32'h33334444,32'h66666666, 0,0,0,0,0});
    tv.push_back('{1,32'hE0,      0,0,0,0,0,          0,1,32'h77777777, 1,0,0,0,1,0, 32'h33334444,32'h66666666, 1,0,32'hE0,0,4'hf});
    tv.push_back('{1,32'hE0,      0,0,0,0,0,          1,0,0,            0,0,0,0,1,0, 32'h77777777,32'h66666666, 0,0,0,0,0});
    tv.push_back('{0,0,           0,0,0,0,0,          0,1,32'h99999999, 0,0,0,0,0,0, 32'h77777777,32'h66666666, 0,0,0,0,0});
    tv.push_back('{0,0,           0,0,0,0,0,          0,0,0,            0,0,0,0,0,0, 32'h77777777,32'h66666666, 1,0,32'hE0,0,4'hf});
    repeat (2) @(posedge clk);
    #1;
    chk("rst bus_req", 32'(bus_req), 0);
    chk("rst bus_addr", bus_addr, 0);
    chk("rst bus_sel", 32'(bus_sel), 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst acks", {30'h0, if_ack, dm_ack}, 0);
    rst = 0;
    foreach (tv[i]) run_vec(tv[i]);
    begin
      int n;
      bit seen;
      n = 0;
      seen = 0;
      dm_req = 1; dm_we = 0; dm_addr = 32'h400; dm_sel = 4'hf; bus_ack = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        #4;
        if (bus_req) n++;
        else if (n > 0) begin
          seen = 1;
          chk("to cycles", n, 16);
          chk("to dm_ack", 32'(dm_ack), 1);
          chk("to bus_err", 32'(bus_err), 1);
          chk("to dm_rdata", dm_rdata, 0);
        end
        @(posedge clk); #1;
      end
      if (!seen) chk("to completion", 0, 1);
      dm_req = 0;
      @(posedge clk); #1;
      chk("to err pulse", 32'(bus_err), 0);
    end
    dm_req = 1; dm_addr = 32'h500;
    @(posedge clk); #1;
    #4;
    chk("rst-seq busy", 32'(bus_req), 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; dm_req = 0; bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    #4;
    chk("midrst bus_req", 32'(bus_req), 0);
    chk("midrst bus_addr", bus_addr, 0);
    chk("midrst if_rdata", if_rdata, 0);
    chk("midrst dm_ack", 32'(dm_ack), 0);
    @(posedge clk); #1;
    bus_ack = 0;
    #4;
    chk("late ack dm_ack", 32'(dm_ack), 0);
    chk("late ack bus_req", 32'(bus_req), 0);
    chk("late ack dm_rdata", dm_rdata, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
